// File: rtl/interval_timer_driver_pkg.sv
// Shared definitions for the interval timer driver: timer register map, bit indices, FSM states.
package interval_timer_driver_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int unsigned STATUS_TO  = 0;
  localparam int unsigned STATUS_RUN = 1;
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_TO,
    ST_WR_STOP,
    ST_STP_CLR,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_CAP
  } state_e;

  function automatic logic [3:0] ctrl_word(input logic start, input logic stop,
                                           input logic cont, input logic ito);
    logic [3:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/interval_timer_driver.sv
// Avalon-MM master that programs the interval timer, services its timeout irq and counts ticks.
// Define INTERVAL_TIMER_DRIVER_SNAP_EN to add a counter snapshot after every serviced timeout.
module interval_timer_driver
  import interval_timer_driver_pkg::*;
#(
  parameter int unsigned TICK_W     = 32,
  parameter int unsigned TMR_ADDR_W = 3,
  parameter int unsigned TMR_DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  output logic                  busy,
  output logic                  tick,
  output logic [TICK_W-1:0]     tick_count,
  output logic                  cfg_err,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic [TMR_ADDR_W-1:0] tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [TMR_DATA_W-1:0] tmr_writedata,
  input  logic [TMR_DATA_W-1:0] tmr_readdata,
  input  logic                  tmr_irq
);

  state_e                state_q, state_d;
  logic [31:0]           period_q, period_d, pend_period_q, pend_period_d;
  logic                  cont_q, cont_d, pend_cont_q, pend_cont_d;
  logic                  start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;
  logic                  ign_irq_q, ign_irq_d;
  logic [TICK_W-1:0]     tick_count_q, tick_count_d;
  logic                  tick_q, tick_d, busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic [TMR_ADDR_W-1:0] addr_q, addr_d;
  logic                  cs_q, cs_d, wr_n_q, wr_n_d;
  logic [TMR_DATA_W-1:0] wdata_q, wdata_d;
  logic                  start_req, stop_req, go_start, req_cont;
  logic [31:0]           req_period;
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
  logic [15:0]           snap_lo_q, snap_lo_d;
  logic [31:0]           snap_value_q, snap_value_d;
  logic                  snap_valid_q, snap_valid_d;
`endif

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    cont_d        = cont_q;
    pend_period_d = pend_period_q;
    pend_cont_d   = pend_cont_q;
    start_pend_d  = start_pend_q;
    stop_pend_d   = stop_pend_q;
    tick_count_d  = tick_count_q;
    cfg_err_d     = 1'b0;
    ign_irq_d     = 1'b0;
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
    snap_lo_d     = snap_lo_q;
    snap_value_d  = snap_value_q;
    snap_valid_d  = 1'b0;
`endif
    // A live pulse takes precedence over a request parked during a bus sequence.
    start_req  = cfg_start | start_pend_q;
    stop_req   = cfg_stop | stop_pend_q;
    req_period = cfg_start ? cfg_period : pend_period_q;
    req_cont   = cfg_start ? cfg_continuous : pend_cont_q;
    go_start   = start_req && (req_period != '0);

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start_req) begin
          start_pend_d = 1'b0;
          cfg_err_d    = (req_period == '0);
        end
        if (go_start) begin
          period_d     = req_period;
          cont_d       = req_cont;
          tick_count_d = '0;
          stop_pend_d  = 1'b0;
          state_d      = ST_WR_PL;
        end else if (state_q == ST_IDLE) begin
          stop_pend_d = 1'b0;
        end else if (stop_req) begin
          stop_pend_d = 1'b0;
          state_d     = ST_WR_STOP;
        end else if (tmr_irq && !ign_irq_q) begin
          tick_count_d = tick_count_q + TICK_W'(1);
          state_d      = ST_CLR_TO;
        end
      end
      ST_WR_PL:   state_d = ST_WR_PH;
      ST_WR_PH:   state_d = ST_WR_CTRL;
      ST_WR_CTRL: state_d = ST_RUN;
      ST_CLR_TO: begin
        // irq is still visible for one cycle after the clearing write
        ign_irq_d = 1'b1;
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
        state_d   = ST_SNAP_WR;
`else
        state_d   = cont_q ? ST_RUN : ST_IDLE;
`endif
      end
      ST_WR_STOP: state_d = ST_STP_CLR;
      ST_STP_CLR: state_d = ST_IDLE;
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
      ST_SNAP_WR: state_d = ST_SNAP_RL;
      ST_SNAP_RL: state_d = ST_SNAP_RH;
      ST_SNAP_RH: begin
        snap_lo_d = 16'(tmr_readdata);
        state_d   = ST_SNAP_CAP;
      end
      ST_SNAP_CAP: begin
        snap_value_d = {16'(tmr_readdata), snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = cont_q ? ST_RUN : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && state_q != ST_RUN) begin
      if (cfg_start) begin
        start_pend_d  = 1'b1;
        pend_period_d = cfg_period;
        pend_cont_d   = cfg_continuous;
      end
      if (cfg_stop) stop_pend_d = 1'b1;
    end

    // Bus phase is decoded from the next state so the registered strobes line up with it.
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      ST_WR_PL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_PERIODL);
        wdata_d = TMR_DATA_W'(period_d[15:0]);
      end
      ST_WR_PH: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_PERIODH);
        wdata_d = TMR_DATA_W'(period_d[31:16]);
      end
      ST_WR_CTRL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_CONTROL);
        wdata_d = TMR_DATA_W'(ctrl_word(1'b1, 1'b0, cont_d, 1'b1));
      end
      ST_WR_STOP: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_CONTROL);
        wdata_d = TMR_DATA_W'(ctrl_word(1'b0, 1'b1, 1'b0, 1'b0));
      end
      ST_CLR_TO, ST_STP_CLR: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_STATUS);
      end
      ST_SNAP_WR: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = TMR_ADDR_W'(REG_SNAPL);
      end
      ST_SNAP_RL: begin
        cs_d = 1'b1; addr_d = TMR_ADDR_W'(REG_SNAPL);
      end
      ST_SNAP_RH: begin
        cs_d = 1'b1; addr_d = TMR_ADDR_W'(REG_SNAPH);
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    tick_d = (state_d == ST_CLR_TO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      cont_q        <= 1'b0;
      pend_period_q <= '0;
      pend_cont_q   <= 1'b0;
      start_pend_q  <= 1'b0;
      stop_pend_q   <= 1'b0;
      ign_irq_q     <= 1'b0;
      tick_count_q  <= '0;
      tick_q        <= 1'b0;
      busy_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      addr_q        <= '0;
      cs_q          <= 1'b0;
      wr_n_q        <= 1'b1;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      cont_q        <= cont_d;
      pend_period_q <= pend_period_d;
      pend_cont_q   <= pend_cont_d;
      start_pend_q  <= start_pend_d;
      stop_pend_q   <= stop_pend_d;
      ign_irq_q     <= ign_irq_d;
      tick_count_q  <= tick_count_d;
      tick_q        <= tick_d;
      busy_q        <= busy_d;
      cfg_err_q     <= cfg_err_d;
      addr_q        <= addr_d;
      cs_q          <= cs_d;
      wr_n_q        <= wr_n_d;
      wdata_q       <= wdata_d;
    end
  end

`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_value = snap_value_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
  assign snap_valid      = 1'b0;
  assign snap_value      = '0;
`endif

  assign busy           = busy_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign cfg_err        = cfg_err_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wr_n_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_interval_timer_driver.sv
// Bench for interval_timer_driver against a behavioural interval timer; snapshot checks need INTERVAL_TIMER_DRIVER_SNAP_EN.
module tb_interval_timer_driver;

  localparam int unsigned TICK_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_start, cfg_stop, cfg_continuous;
  logic [31:0]       cfg_period;
  logic              busy, tick, cfg_err, snap_valid;
  logic [TICK_W-1:0] tick_count;
  logic [31:0]       snap_value;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect, tmr_write_n, tmr_irq;
  logic [15:0]       tmr_writedata, tmr_readdata;

  interval_timer_driver #(.TICK_W(TICK_W), .TMR_ADDR_W(3), .TMR_DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .busy(busy), .tick(tick),
    .tick_count(tick_count), .cfg_err(cfg_err), .snap_valid(snap_valid), .snap_value(snap_value),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural interval timer: period+1 clocks per timeout, STATUS write clears TO.
  logic [31:0] t_per, t_cnt, t_snap;
  logic        t_run, t_cont, t_ito, t_to;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_per <= '0; t_cnt <= '0; t_snap <= '0; t_run <= 1'b0; t_cont <= 1'b0;
      t_ito <= 1'b0; t_to <= 1'b0; tmr_readdata <= '0;
    end else begin
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[3]) t_run <= 1'b0;
            if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
          end
          3'd2: begin t_per[15:0] <= tmr_writedata; t_run <= 1'b0; end
          3'd3: begin t_per[31:16] <= tmr_writedata; t_run <= 1'b0; end
          3'd4: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1;
          t_cnt <= t_per;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd0: tmr_readdata <= {14'd0, t_run, t_to};
          3'd1: tmr_readdata <= {12'd0, 1'b0, 1'b0, t_cont, t_ito};
          3'd4: tmr_readdata <= t_snap[15:0];
          3'd5: tmr_readdata <= t_snap[31:16];
          default: tmr_readdata <= '0;
        endcase
      end
    end
  end
  assign tmr_irq = t_to & t_ito;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    bit          chk_data;
  } wr_t;

  wr_t               exp_wr_q[$];
  logic [TICK_W-1:0] exp_tick_q[$];
  int unsigned       tick_cyc_q[$];
  int unsigned       n_cmp = 0, n_err = 0, snaps_seen = 0;
  logic [31:0]       cur_period = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pops expected bus writes and tick counts as the DUT produces them.
  always @(negedge clk) begin
    wr_t         e;
    logic [TICK_W-1:0] et;
    if (reset_n) begin
      if (tmr_chipselect && !tmr_write_n) begin
        check_eq("wr_expected", 64'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check_eq("wr_addr", 64'(tmr_address), 64'(e.addr));
          if (e.chk_data) check_eq("wr_data", 64'(tmr_writedata), 64'(e.data));
        end
      end
      if (tick) begin
        tick_cyc_q.push_back(cyc);
        check_eq("tick_expected", 64'(exp_tick_q.size() != 0), 1);
        if (exp_tick_q.size() != 0) begin
          et = exp_tick_q.pop_front();
          check_eq("tick_count", 64'(tick_count), 64'(et));
        end
      end
      if (snap_valid) begin
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
        snaps_seen++;
        check_eq("snap_range", 64'((snap_value <= cur_period) && (snap_value + 9 >= cur_period)), 1);
`else
        check_eq("snap_valid_off", 64'(snap_valid), 0);
`endif
      end
    end
  end

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d, input bit chk);
    wr_t e;
    e.addr = a; e.data = d; e.chk_data = chk;
    exp_wr_q.push_back(e);
  endtask

  task automatic push_prog(input logic [31:0] p, input logic cont);
    push_wr(3'd2, p[15:0], 1'b1);
    push_wr(3'd3, p[31:16], 1'b1);
    push_wr(3'd1, cont ? 16'h0007 : 16'h0005, 1'b1);
  endtask

  task automatic push_tick(input logic [TICK_W-1:0] cnt);
    exp_tick_q.push_back(cnt);
    push_wr(3'd0, 16'h0000, 1'b1);
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
    push_wr(3'd4, 16'h0000, 1'b0);
`endif
  endtask

  task automatic pulse_start(input logic [31:0] p, input logic cont);
    @(negedge clk);
    cfg_period = p; cfg_continuous = cont; cfg_start = 1'b1; cur_period = p;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_ticks(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned got = 0;
    int unsigned c = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (tick) got++;
    end
    check_eq(tag, 64'(got), 64'(n));
  endtask

  task automatic wait_idle(input int unsigned budget, input string tag);
    int unsigned c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, 64'(busy), 0);
  endtask

  task automatic stop_timer();
    push_wr(3'd1, 16'h0008, 1'b1);
    push_wr(3'd0, 16'h0000, 1'b1);
    @(negedge clk); cfg_stop = 1'b1;
    @(negedge clk); cfg_stop = 1'b0;
    wait_idle(20, "stop_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, sz;
    reset_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_tick", 64'(tick), 0);
    check_eq("rst_tick_count", 64'(tick_count), 0);
    check_eq("rst_cfg_err", 64'(cfg_err), 0);
    check_eq("rst_snap_valid", 64'(snap_valid), 0);
    check_eq("rst_snap_value", 64'(snap_value), 0);
    check_eq("rst_cs", 64'(tmr_chipselect), 0);
    check_eq("rst_write_n", 64'(tmr_write_n), 1);
    check_eq("rst_addr", 64'(tmr_address), 0);
    check_eq("rst_wdata", 64'(tmr_writedata), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero period is rejected with no bus traffic.
    pulse_start(32'd0, 1'b1);
    check_eq("zero_cfg_err", 64'(cfg_err), 1);
    check_eq("zero_busy", 64'(busy), 0);
    @(negedge clk);
    check_eq("zero_cfg_err_pulse", 64'(cfg_err), 0);
    n = 0;
    repeat (5) begin @(negedge clk); if (tmr_chipselect) n++; end
    check_eq("zero_bus_quiet", 64'(n), 0);
    check_eq("zero_busy_stays", 64'(busy), 0);

    // Continuous, period 99: tick every 100 clocks.
    push_prog(32'd99, 1'b1);
    for (int unsigned i = 1; i <= 5; i++) push_tick(TICK_W'(i));
    pulse_start(32'd99, 1'b1);
    check_eq("start_busy_c1", 64'(busy), 1);
    check_eq("start_addr_c1", 64'(tmr_address), 2);
    repeat (2) @(negedge clk);
    check_eq("start_addr_c3", 64'(tmr_address), 1);
    @(negedge clk);
    check_eq("run_bus_idle", 64'(tmr_chipselect), 0);
    wait_ticks(5, 700, "cont_ticks");
    @(negedge clk);
    sz = tick_cyc_q.size();
    if (sz >= 5)
      for (int unsigned i = sz - 4; i < sz; i++)
        check_eq("tick_interval", 64'(tick_cyc_q[i] - tick_cyc_q[i-1]), 100);
    check_eq("cont_tick_count", 64'(tick_count), 5);
    repeat (10) @(negedge clk);
    stop_timer();
    check_eq("cont_stop_irq", 64'(tmr_irq), 0);

    // One-shot, period 9: one tick, then idle.
    push_prog(32'd9, 1'b0);
    push_tick(TICK_W'(1));
    pulse_start(32'd9, 1'b0);
    wait_ticks(1, 100, "oneshot_tick");
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
    check_eq("oneshot_idle_lat", 64'(n), 5);
`else
    check_eq("oneshot_idle_lat", 64'(n), 1);
`endif
    repeat (40) @(negedge clk);
    check_eq("oneshot_tick_count", 64'(tick_count), 1);
    check_eq("oneshot_irq_low", 64'(tmr_irq), 0);
    check_eq("oneshot_busy", 64'(busy), 0);

    // Stop arriving in the same RUN cycle as the irq wins; no tick.
    push_prog(32'd19, 1'b1);
    pulse_start(32'd19, 1'b1);
    n = 0;
    while (!tmr_irq && n < 60) begin @(negedge clk); n++; end
    check_eq("stopirq_irq_seen", 64'(tmr_irq), 1);
    push_wr(3'd1, 16'h0008, 1'b1);
    push_wr(3'd0, 16'h0000, 1'b1);
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    check_eq("stopirq_no_tick", 64'(tick), 0);
    wait_idle(20, "stopirq_idle");
    @(negedge clk);
    check_eq("stopirq_irq_low", 64'(tmr_irq), 0);
    check_eq("stopirq_tick_count", 64'(tick_count), 0);

    // tick_count wraps from all-ones to zero.
    push_prog(32'd9, 1'b1);
    push_tick('0);
    pulse_start(32'd9, 1'b1);
    repeat (3) @(negedge clk);
    force dut.tick_count_q = '1;
    @(negedge clk);
    release dut.tick_count_q;
    wait_ticks(1, 40, "wrap_tick");
    check_eq("wrap_tick_count", 64'(tick_count), 0);
    repeat (3) @(negedge clk);
    stop_timer();

`ifdef INTERVAL_TIMER_DRIVER_SNAP_EN
    // Snapshot after each tick, value close to the reload value.
    n = snaps_seen;
    push_prog(32'd999, 1'b1);
    push_tick(TICK_W'(1));
    push_tick(TICK_W'(2));
    pulse_start(32'd999, 1'b1);
    wait_ticks(2, 2200, "snap_ticks");
    repeat (6) @(negedge clk);
    check_eq("snap_count", 64'(snaps_seen - n), 2);
    stop_timer();
`else
    check_eq("snap_value_off", 64'(snap_value), 0);
`endif

    repeat (5) @(negedge clk);
    check_eq("wr_q_drained", 64'(exp_wr_q.size()), 0);
    check_eq("tick_q_drained", 64'(exp_tick_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
